// File: rtl/connect4_pkg.sv
// Shared board constants and the drop animator state encoding.
//   ROWS/COLS   : board geometry, row 0 is the top row
//   ROW_W/COL_W : widths of row and column indices
//   state_e     : drop animator FSM states
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    LAND = 2'd2
  } state_e;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the divided slow clock (a plain level) into the system clock domain
// and turns each rising edge into a single-cycle pulse.
//   clk_in     : system clock
//   rst        : synchronous, active-high reset
//   tick_level : divided slow clock, asynchronous level
//   tick_pulse : one-cycle pulse per rising edge of tick_level
module tick_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_level,
  output logic tick_pulse
);

  logic s1_q, s2_q, s3_q;

  // Reset loads the chain as "already high": a level that is high when reset
  // releases is then never mistaken for a fresh edge. A level that is low
  // simply drains through as a falling transition, which is never reported.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= tick_level;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/drop_animator.sv
// Walks a falling token down one board column, one row per slow-tick edge,
// then reports the landing row.
//   clk_in      : system clock (only clock)
//   rst         : synchronous, active-high reset
//   tick_level  : divided slow clock level; rising edges are animation steps
//   start       : drop request, sampled only in IDLE
//   col         : requested column
//   player      : owner of the token
//   col_height  : tokens already in col, valid with start
//   busy        : high in FALL and LAND
//   anim_valid  : high in FALL; anim_row/anim_col/anim_player meaningful
//   anim_row    : current falling-token row
//   anim_col    : latched column
//   anim_player : latched player
//   done        : one-cycle pulse on landing
//   land_row    : landing row, held until the next landing
//   reject      : one-cycle pulse when a request is refused
//   dbg_state   : current FSM state, for observation only
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// or rejected at the edge it is sampled in IDLE and silently dropped while
// busy. done and reject are single-cycle result pulses with no back-pressure.
module drop_animator
  import connect4_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_level,
  input  logic             start,
  input  logic [COL_W-1:0] col,
  input  logic             player,
  input  logic [ROW_W-1:0] col_height,
  output logic             busy,
  output logic             anim_valid,
  output logic [ROW_W-1:0] anim_row,
  output logic [COL_W-1:0] anim_col,
  output logic             anim_player,
  output logic             done,
  output logic [ROW_W-1:0] land_row,
  output logic             reject,
  output logic [1:0]       dbg_state
);

  logic tick_pulse;

  tick_edge_sync u_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_level (tick_level),
    .tick_pulse (tick_pulse)
  );

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] target_q, target_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             player_q, player_d;
  logic [ROW_W-1:0] land_q, land_d;
  logic             reject_q, reject_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      target_q <= '0;
      col_q    <= '0;
      player_q <= 1'b0;
      land_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      target_q <= target_d;
      col_q    <= col_d;
      player_q <= player_d;
      land_q   <= land_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    target_d = target_q;
    col_d    = col_q;
    player_d = player_q;
    land_d   = land_q;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A tick edge coinciding with an accepted start is dropped on purpose:
        // the token sits at row 0 until the next edge.
        if (start) begin
          if ((col >= COL_W'(COLS)) || (col_height >= ROW_W'(ROWS))) begin
            reject_d = 1'b1;
          end else begin
            col_d    = col;
            player_d = player;
            target_d = ROW_W'(ROWS - 1) - col_height;
            row_d    = '0;
            state_d  = FALL;
          end
        end
      end
      FALL: begin
        if (tick_pulse) begin
          if (row_q == target_q) begin
            // Load land_row on entry to LAND so it is valid alongside done.
            land_d  = target_q;
            state_d = LAND;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      LAND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign anim_valid  = (state_q == FALL);
  assign done        = (state_q == LAND);
  assign anim_row    = row_q;
  assign anim_col    = col_q;
  assign anim_player = player_q;
  assign land_row    = land_q;
  assign reject      = reject_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_drop_animator.sv
module tb_drop_animator;

  logic       clk_in;
  logic       rst;
  logic       tick_level;
  logic       start;
  logic [2:0] col;
  logic       player;
  logic [2:0] col_height;
  logic       busy;
  logic       anim_valid;
  logic [2:0] anim_row;
  logic [2:0] anim_col;
  logic       anim_player;
  logic       done;
  logic [2:0] land_row;
  logic       reject;
  logic [1:0] dbg_state;

  drop_animator dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_level  (tick_level),
    .start       (start),
    .col         (col),
    .player      (player),
    .col_height  (col_height),
    .busy        (busy),
    .anim_valid  (anim_valid),
    .anim_row    (anim_row),
    .anim_col    (anim_col),
    .anim_player (anim_player),
    .done        (done),
    .land_row    (land_row),
    .reject      (reject),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // expected landing events: {col[5:3], land_row[2:0]}
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;

  logic [2:0] last_land;
  logic [2:0] last_col;
  logic       last_player;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_land_row", int'(land_row), int'(mon_e[2:0]));
        check("sb_anim_col", int'(anim_col), int'(mon_e[5:3]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_rise;
    tick_level = 1'b1;
    repeat (3) step;
  endtask

  task automatic tick_fall;
    tick_level = 1'b0;
    repeat (3) step;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 50 && busy; i++) step;
    check("idle_wait", int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(anim_valid), 0);
    check({tag, "_row"}, int'(anim_row), 0);
    check({tag, "_col"}, int'(anim_col), 0);
    check({tag, "_player"}, int'(anim_player), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_land"}, int'(land_row), 0);
    check({tag, "_reject"}, int'(reject), 0);
    check({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // Ticks the token from row 0 down to tgt, then the landing tick.
  task automatic finish_drop(input logic [2:0] tgt, input bit ovl, input logic [2:0] c);
    for (int k = 1; k <= int'(tgt); k++) begin
      tick_rise;
      check("step_row", int'(anim_row), k);
      check("step_valid", int'(anim_valid), 1);
      tick_fall;
      if (ovl && k == 1) begin
        start = 1'b1; col = 3'd1; col_height = 3'd0; player = ~player;
        step;
        start = 1'b0;
        check("ovl_reject", int'(reject), 0);
        check("ovl_col", int'(anim_col), int'(c));
        check("ovl_row", int'(anim_row), 1);
      end
    end
    tick_level = 1'b1;
    step; step;
    check("pre_land_done", int'(done), 0);
    check("pre_land_valid", int'(anim_valid), 1);
    check("pre_land_row", int'(anim_row), int'(tgt));
    step;
    check("land_done", int'(done), 1);
    check("land_valid", int'(anim_valid), 0);
    check("land_busy", int'(busy), 1);
    check("land_row", int'(land_row), int'(tgt));
    check("land_anim_row", int'(anim_row), int'(tgt));
    step;
    check("post_land_done", int'(done), 0);
    check("post_land_busy", int'(busy), 0);
    tick_fall;
    last_land = tgt;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] col;
    logic [2:0] h;
    logic       p;
    bit         ovl;
    bit         exp_ok;
    logic [2:0] exp_land;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst = 1'b1; tick_level = 1'b0; start = 1'b0;
    col = '0; player = 1'b0; col_height = '0;
    last_land = '0; last_col = '0; last_player = 1'b0;

    vecs[0] = '{col: 3'd3, h: 3'd0, p: 1'b1, ovl: 1'b0, exp_ok: 1'b1, exp_land: 3'd5};
    vecs[1] = '{col: 3'd2, h: 3'd5, p: 1'b0, ovl: 1'b0, exp_ok: 1'b1, exp_land: 3'd0};
    vecs[2] = '{col: 3'd4, h: 3'd6, p: 1'b1, ovl: 1'b0, exp_ok: 1'b0, exp_land: 3'd0};
    vecs[3] = '{col: 3'd7, h: 3'd0, p: 1'b0, ovl: 1'b0, exp_ok: 1'b0, exp_land: 3'd0};
    vecs[4] = '{col: 3'd0, h: 3'd3, p: 1'b1, ovl: 1'b1, exp_ok: 1'b1, exp_land: 3'd2};
    vecs[5] = '{col: 3'd6, h: 3'd1, p: 1'b0, ovl: 1'b0, exp_ok: 1'b1, exp_land: 3'd4};
    for (int i = 6; i < 12; i++) begin
      vecs[i].col = 3'($urandom_range(0, 7));
      vecs[i].h   = 3'($urandom_range(0, 7));
      vecs[i].p   = 1'($urandom_range(0, 1));
      vecs[i].ovl = 1'($urandom_range(0, 1));
      vecs[i].exp_ok   = (vecs[i].col < 3'd7) && (vecs[i].h < 3'd6);
      vecs[i].exp_land = 3'd5 - vecs[i].h;
    end

    repeat (3) step;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) step;

    // table-driven drops
    for (int i = 0; i < 12; i++) begin
      wait_idle;
      start = 1'b1; col = vecs[i].col; col_height = vecs[i].h; player = vecs[i].p;
      step;
      start = 1'b0;
      if (vecs[i].exp_ok) begin
        exp_q.push_back({vecs[i].col, vecs[i].exp_land});
        check("acc_busy", int'(busy), 1);
        check("acc_valid", int'(anim_valid), 1);
        check("acc_row", int'(anim_row), 0);
        check("acc_col", int'(anim_col), int'(vecs[i].col));
        check("acc_player", int'(anim_player), int'(vecs[i].p));
        check("acc_reject", int'(reject), 0);
        last_col = vecs[i].col; last_player = vecs[i].p;
        finish_drop(vecs[i].exp_land, vecs[i].ovl, vecs[i].col);
      end else begin
        check("rej_pulse", int'(reject), 1);
        check("rej_busy", int'(busy), 0);
        check("rej_land", int'(land_row), int'(last_land));
        check("rej_col", int'(anim_col), int'(last_col));
        check("rej_player", int'(anim_player), int'(last_player));
        step;
        check("rej_pulse_end", int'(reject), 0);
      end
    end

    // start coinciding with a tick edge: the tick is consumed
    wait_idle;
    tick_level = 1'b1;
    step; step;
    start = 1'b1; col = 3'd4; col_height = 3'd2; player = 1'b1;
    step;
    start = 1'b0;
    exp_q.push_back({3'd4, 3'd3});
    check("coin_valid", int'(anim_valid), 1);
    check("coin_row", int'(anim_row), 0);
    repeat (3) step;
    check("coin_row_hold", int'(anim_row), 0);
    tick_fall;
    last_col = 3'd4; last_player = 1'b1;
    finish_drop(3'd3, 1'b0, 3'd4);

    // reset mid-FALL at row 2, tick held high through and after reset
    wait_idle;
    start = 1'b1; col = 3'd5; col_height = 3'd0; player = 1'b1;
    step;
    start = 1'b0;
    exp_q.push_back({3'd5, 3'd5});
    tick_rise; tick_fall;
    tick_rise;
    check("mid_row", int'(anim_row), 2);
    tick_fall;
    rst = 1'b1; tick_level = 1'b1;
    step;
    check_all_zero("midrst");
    exp_q.delete();
    rst = 1'b0;
    last_land = '0; last_col = '0; last_player = 1'b0;
    repeat (6) step;
    check("rst_hi_busy", int'(busy), 0);
    start = 1'b1; col = 3'd2; col_height = 3'd5; player = 1'b0;
    step;
    start = 1'b0;
    exp_q.push_back({3'd2, 3'd0});
    repeat (6) step;
    check("rst_hi_no_step_busy", int'(busy), 1);
    check("rst_hi_no_step_valid", int'(anim_valid), 1);
    check("rst_hi_no_step_done", int'(done), 0);
    tick_fall;
    finish_drop(3'd0, 1'b0, 3'd2);

    repeat (4) step;
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
